// File: rtl/seq_sdiv.sv
// seq_sdiv: multi-cycle signed divider; quot/rem follow Verilog signed / and %.
// Latency: done is high DATAWIDTH+2 edges after start is raised (1 edge for b==0).
// Backpressure: none; start is only sampled in IDLE and is ignored while busy.
//
// Ports:
//   Clk          rising-edge clock
//   Rst          asynchronous active-low reset
//   start        request a division (sampled only when idle)
//   a, b         signed dividend / divisor (only needed at the sampling edge)
//   quot, rem    signed result, held until the next completed operation
//   busy         high whenever an operation is in progress
//   done         one-cycle pulse marking quot/rem/div_by_zero valid
//   div_by_zero  error flag for the last completed operation
module seq_sdiv #(
  parameter int DATAWIDTH = 64
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        start,
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic signed [DATAWIDTH-1:0] b,
  output logic signed [DATAWIDTH-1:0] quot,
  output logic signed [DATAWIDTH-1:0] rem,
  output logic                        busy,
  output logic                        done,
  output logic                        div_by_zero
);

  localparam int W  = DATAWIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [W-1:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  dvd;      // dividend magnitude; quotient bits shift in from the right
  logic [W-1:0]  dvs;      // divisor magnitude
  logic [W:0]    prem;     // partial remainder
  logic [CW-1:0] cnt;
  logic          sign_q;
  logic          sign_r;

  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic [W+1:0]  shifted;
  logic [W+1:0]  diff;
  logic          borrow;

  // |x| as an unsigned W-bit value; |-2^(W-1)| = 2^(W-1) still fits.
  always_comb begin
    mag_a = a[W-1] ? (~$unsigned(a) + ONE) : $unsigned(a);
    mag_b = b[W-1] ? (~$unsigned(b) + ONE) : $unsigned(b);
  end

  // One restoring step: bring down the next dividend bit and trial-subtract.
  // prem < dvs always holds, so shifted never exceeds W+1 significant bits and
  // the top bit of diff is a clean borrow.
  always_comb begin
    shifted = {prem, dvd[W-1]};
    diff    = shifted - {2'b00, dvs};
    borrow  = diff[W+1];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= a[W-1] ^ b[W-1];
            sign_r <= a[W-1];
            dvd    <= mag_a;
            dvs    <= mag_b;
            prem   <= '0;
            if (b == '0) begin
              quot        <= '1;
              rem         <= a;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              cnt   <= CW'(W - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= borrow ? shifted[W:0] : diff[W:0];
          dvd  <= {dvd[W-2:0], ~borrow};
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          quot        <= sign_q ? (~dvd + ONE) : dvd;
          rem         <= sign_r ? (~prem[W-1:0] + ONE) : prem[W-1:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sdiv.sv
// Directed bench for seq_sdiv at DATAWIDTH=8 with hand-computed expectations.
module tb_seq_sdiv;

  logic              Clk;
  logic              Rst;
  logic              start;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic signed [7:0] quot;
  logic signed [7:0] rem;
  logic              busy;
  logic              done;
  logic              div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_sdiv #(.DATAWIDTH(8)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .start(start),
    .a(a),
    .b(b),
    .quot(quot),
    .rem(rem),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raises start at a negedge, then samples #1 after every rising edge.
  // lat = index of the first sample with done high (1 = sampling edge), -1 on timeout.
  // inj > 0 raises a second start with other operands at that sample, for one cycle.
  task automatic run_op(input logic signed [7:0] av, input logic signed [7:0] bv,
                        input int inj, output int lat, output int busy_cyc);
    bit got;
    got      = 1'b0;
    lat      = -1;
    busy_cyc = 0;
    @(negedge Clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge Clk);
      #1;
      if (i == 1) begin
        start = 1'b0;
        a     = 8'sh5A;   // operands are not required to stay stable
        b     = 8'sh00;
      end
      if (inj > 0 && i == inj) begin
        start = 1'b1;
        a     = 8'sd50;
        b     = 8'sd3;
      end
      if (inj > 0 && i == inj + 1) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  // Result check plus the cycle after done: pulse gone, block idle.
  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic [7:0] eq, input logic [7:0] er, input logic ez);
    chki({tag, "_lat"}, lat, exp_lat);
    chk8({tag, "_quot"}, quot, eq);
    chk8({tag, "_rem"}, rem, er);
    chk8({tag, "_dbz"}, {7'd0, div_by_zero}, {7'd0, ez});
    @(posedge Clk);
    #1;
    chk8({tag, "_done_pulse"}, {7'd0, done}, 8'd0);
    chk8({tag, "_idle"}, {7'd0, busy}, 8'd0);
    chk8({tag, "_hold_quot"}, quot, eq);
  endtask

  initial begin
    int lat;
    int bc;
    int seen;

    Rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    chk8("rst_quot", quot, 8'h00);
    chk8("rst_rem", rem, 8'h00);
    chk8("rst_flags", {5'd0, busy, done, div_by_zero}, 8'h00);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;

    // 100 / 7
    run_op(8'sd100, 8'sd7, 0, lat, bc);
    chki("p_p_busy_cycles", bc, 10);
    check_result("p_p", lat, 10, 8'd14, 8'd2, 1'b0);

    // sign combinations
    run_op(-8'sd100, 8'sd7, 0, lat, bc);
    check_result("n_p", lat, 10, 8'hF2, 8'hFE, 1'b0);
    run_op(8'sd100, -8'sd7, 0, lat, bc);
    check_result("p_n", lat, 10, 8'hF2, 8'h02, 1'b0);
    run_op(-8'sd100, -8'sd7, 0, lat, bc);
    check_result("n_n", lat, 10, 8'h0E, 8'hFE, 1'b0);

    // overflow wraps, small dividend
    run_op(8'sh80, -8'sd1, 0, lat, bc);
    check_result("ovf", lat, 10, 8'h80, 8'h00, 1'b0);
    run_op(8'sd7, -8'sd100, 0, lat, bc);
    check_result("small", lat, 10, 8'h00, 8'h07, 1'b0);

    // divide by zero, then a normal op clears the flag
    run_op(8'sd5, 8'sd0, 0, lat, bc);
    chki("dbz_busy_cycles", bc, 1);
    check_result("dbz", lat, 1, 8'hFF, 8'h05, 1'b1);
    run_op(8'sd20, 8'sd4, 0, lat, bc);
    check_result("after_dbz", lat, 10, 8'h05, 8'h00, 1'b0);

    // second start during CALC is ignored
    run_op(8'sd100, 8'sd7, 3, lat, bc);
    check_result("ign_start", lat, 10, 8'h0E, 8'h02, 1'b0);

    // reset in the 4th CALC cycle aborts the operation
    @(negedge Clk);
    a     = 8'sd100;
    b     = 8'sd7;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    chk8("pre_rst_busy", {7'd0, busy}, 8'd1);
    Rst = 1'b0;
    #1;
    chk8("mid_rst_quot", quot, 8'h00);
    chk8("mid_rst_rem", rem, 8'h00);
    chk8("mid_rst_flags", {5'd0, busy, done, div_by_zero}, 8'h00);
    @(negedge Clk);
    Rst = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge Clk);
      #1;
      if (done || busy) seen++;
    end
    chki("rst_no_done", seen, 0);
    run_op(8'sd9, 8'sd2, 0, lat, bc);
    check_result("post_rst", lat, 10, 8'h04, 8'h01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
